// File: rtl/cpu_pkg.sv
// Shared types and decode helpers for the cpu_control multi-cycle RV32I subset core.
package cpu_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_REG    = 7'b0110011;

    localparam logic [2:0] F3_ADD = 3'b000, F3_SLL = 3'b001, F3_SLT = 3'b010, F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR = 3'b100, F3_SR  = 3'b101, F3_OR  = 3'b110, F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000, F3_BNE = 3'b001, F3_BLT = 3'b100, F3_BGE  = 3'b101;
    localparam logic [2:0] F3_W   = 3'b010;

    // Anything outside the supported subset (including EBREAK) is not legal and halts the core.
    function automatic logic is_legal(logic [6:0] opc, logic [2:0] f3);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL: return 1'b1;
            OPC_JALR:                    return f3 == F3_ADD;
            OPC_BRANCH:                  return f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE};
            OPC_LOAD, OPC_STORE:         return f3 == F3_W;
            OPC_IMM, OPC_REG:            return f3 != F3_SLTU;
            default:                     return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] imm_of(logic [31:0] i);
        case (i[6:0])
            OPC_LUI, OPC_AUIPC: return {i[31:12], 12'b0};
            OPC_JAL:            return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            OPC_BRANCH:         return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            OPC_STORE:          return {{21{i[31]}}, i[30:25], i[11:7]};
            default:            return {{21{i[31]}}, i[30:20]};
        endcase
    endfunction

    function automatic alu_op_t alu_sel(logic [6:0] opc, logic [2:0] f3, logic f7b5);
        if (opc != OPC_IMM && opc != OPC_REG) return ALU_ADD;
        case (f3)
            F3_ADD:  return (opc == OPC_REG && f7b5) ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return f7b5 ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            F3_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [31:0] alu(alu_op_t op, logic [31:0] a, logic [31:0] b);
        case (op)
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
            ALU_SLL: return a << b[4:0];
            ALU_SRL: return a >> b[4:0];
            ALU_SRA: return $signed(a) >>> b[4:0];
            default: return a + b;
        endcase
    endfunction

endpackage

// File: rtl/cpu_control_if.sv
// Single-port memory bus between the core and its unified memory.
interface cpu_control_if #(parameter int AW = 11);
    logic          read;
    logic          mem_wen;
    logic [AW-1:0] address_bus;
    logic [31:0]   data_w;
    logic [31:0]   data_r;
    logic          mem_rdy;

    modport master (output read, mem_wen, address_bus, data_w, input data_r, mem_rdy);
    modport slave  (input read, mem_wen, address_bus, data_w, output data_r, mem_rdy);
endinterface

// File: rtl/cpu_control_dm.sv
// Memory address mux: instruction fetch uses pc, data access uses the ALU result y.
module cpu_control_dm #(parameter int AW = 11) (
    input  logic          sel_y,
    input  logic [AW-1:0] pc_word,
    input  logic [AW-1:0] y_word,
    output logic [AW-1:0] mem_addr
);
    assign mem_addr = sel_y ? y_word : pc_word;
endmodule

// File: rtl/cpu_control_mem.sv
// Unified word memory: registered read data with mem_rdy one cycle after a read, writes on the request edge.
module cpu_control_mem #(
    parameter int MEM_WORDS = 2048,
    parameter int AW        = 11
) (
    input logic           clk,
    input logic           rst,
    cpu_control_if.slave  bus
);
    logic [31:0] bank [0:MEM_WORDS-1];

    // NOTE: the array and its read register have no reset so contents survive rst and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (bus.mem_wen) bank[bus.address_bus] <= bus.data_w;
        if (bus.read)    bus.data_r <= bank[bus.address_bus];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bus.mem_rdy <= 1'b0;
        else      bus.mem_rdy <= bus.read;
    end
endmodule

// File: rtl/cpu_control.sv
// Multi-cycle RV32I subset core: IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT over a single-port memory.
module cpu_control import cpu_pkg::*; #(
    parameter int          MEM_WORDS = 2048,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        halted,
    output logic [31:0] pc
);
    localparam int AW = $clog2(MEM_WORDS);

    state_t        state, state_nxt;
    logic [31:0]   instr, y, next_pc, rs1v, rs2v, ld_data;
    logic [31:0]   regs [0:31];
    logic          pend, sel_y;
    logic          read, write, mem_wen, mem_rdy;
    logic [31:0]   data_r, data_w;
    logic [AW-1:0] address_bus;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, op_a, op_b, alu_y, target, wb_val;
    logic        taken, rd_we;

    cpu_control_if #(.AW(AW)) bus ();

    cpu_control_mem #(.MEM_WORDS(MEM_WORDS), .AW(AW)) m (.clk(clk), .rst(rst), .bus(bus.slave));

    cpu_control_dm #(.AW(AW)) dm (
        .sel_y(sel_y), .pc_word(pc[AW+1:2]), .y_word(y[AW+1:2]), .mem_addr(address_bus)
    );

    assign bus.read        = read;
    assign bus.mem_wen     = mem_wen;
    assign bus.address_bus = address_bus;
    assign bus.data_w      = data_w;
    assign data_r          = bus.data_r;
    assign mem_rdy         = bus.mem_rdy;
    assign write           = mem_wen;
    assign data_w          = rs2v;
    assign halted          = (state == HALT);

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign imm    = imm_of(instr);

    // NOTE: every combinational output is defaulted first so no path through the case leaves a latch.
    always_comb begin
        state_nxt = state;
        read      = 1'b0;
        mem_wen   = 1'b0;
        sel_y     = 1'b0;
        case (state)
            IDLE:   if (enable) state_nxt = FETCH;
            FETCH: begin
                read = !pend;
                if (mem_rdy) state_nxt = DECODE;
            end
            DECODE: state_nxt = is_legal(opcode, f3) ? EXEC : HALT;
            EXEC:   state_nxt = (opcode == OPC_LOAD || opcode == OPC_STORE) ? MEM : WB;
            MEM: begin
                sel_y = 1'b1;
                if (opcode == OPC_STORE) begin
                    mem_wen   = 1'b1;
                    state_nxt = WB;
                end else begin
                    read = !pend;
                    if (mem_rdy) state_nxt = WB;
                end
            end
            WB:      state_nxt = enable ? FETCH : IDLE;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        op_a = rs1v;
        op_b = imm;
        case (opcode)
            OPC_LUI:            op_a = '0;
            OPC_AUIPC, OPC_JAL: op_a = pc;
            OPC_REG:            op_b = rs2v;
            default:            ;
        endcase
        alu_y = alu(alu_sel(opcode, f3, instr[30]), op_a, op_b);

        case (f3)
            F3_BEQ:  taken = (rs1v == rs2v);
            F3_BNE:  taken = (rs1v != rs2v);
            F3_BLT:  taken = ($signed(rs1v) <  $signed(rs2v));
            F3_BGE:  taken = ($signed(rs1v) >= $signed(rs2v));
            default: taken = 1'b0;
        endcase

        case (opcode)
            OPC_JAL:    target = alu_y;
            OPC_JALR:   target = {alu_y[31:1], 1'b0};
            OPC_BRANCH: target = taken ? pc + imm : pc + 32'd4;
            default:    target = pc + 32'd4;
        endcase

        rd_we  = (rd != 5'd0) && (opcode inside {OPC_LUI, OPC_AUIPC, OPC_IMM, OPC_REG,
                                                 OPC_LOAD, OPC_JAL, OPC_JALR});
        wb_val = (opcode == OPC_LOAD) ? ld_data :
                 (opcode == OPC_JAL || opcode == OPC_JALR) ? pc + 32'd4 : y;
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            instr   <= '0;
            pend    <= 1'b0;
            y       <= '0;
            next_pc <= RESET_PC;
            rs1v    <= '0;
            rs2v    <= '0;
            ld_data <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            state <= state_nxt;
            if (read)         pend <= 1'b1;
            else if (mem_rdy) pend <= 1'b0;
            case (state)
                FETCH:  if (mem_rdy) instr <= data_r;
                DECODE: begin
                    rs1v <= (rs1 == 5'd0) ? '0 : regs[rs1];
                    rs2v <= (rs2 == 5'd0) ? '0 : regs[rs2];
                end
                EXEC: begin
                    y       <= alu_y;
                    next_pc <= target;
                end
                MEM:    if (mem_rdy) ld_data <= data_r;
                WB: begin
                    pc <= next_pc;
                    if (rd_we) regs[rd] <= wb_val;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: table of ALU programs plus hand-written multi-cycle sequences.
module tb_cpu_control;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        halted;
    logic [31:0] pc;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] SENT   = 32'hA5A5_A5A5;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    cpu_control dut (.clk(clk), .rst(rst), .enable(enable), .halted(halted), .pc(pc));

    // Observation bundle for the memory bus.
    cpu_control_if #(.AW(11)) mon ();
    assign mon.read        = dut.read;
    assign mon.mem_wen     = dut.mem_wen;
    assign mon.address_bus = dut.address_bus;
    assign mon.data_w      = dut.data_w;
    assign mon.data_r      = dut.data_r;
    assign mon.mem_rdy     = dut.mem_rdy;

    always #5 clk = ~clk;

    typedef struct { logic [31:0] idx; logic [31:0] val; string name; } sb_t;
    sb_t sbq[$];

    typedef struct { string name; logic [31:0] i0, i1, i2, exp; } vec_t;
    vec_t vecs[16];

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction
    function automatic logic [31:0] addi(int rd, int rs1, int imm); return enc_i(imm, rs1, 0, rd, 7'h13); endfunction
    function automatic logic [31:0] opr(int f7, int f3, int rd, int rs1, int rs2);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] sw(int rs2, int rs1, int imm);
        return {7'(imm >> 5), 5'(rs2), 5'(rs1), 3'b010, 5'(imm), 7'h23};
    endfunction
    function automatic logic [31:0] lw(int rd, int rs1, int imm); return enc_i(imm, rs1, 2, rd, 7'h03); endfunction
    function automatic logic [31:0] lui(int rd, int imm20); return {20'(imm20), 5'(rd), 7'h37}; endfunction
    function automatic logic [31:0] auipc(int rd, int imm20); return {20'(imm20), 5'(rd), 7'h17}; endfunction
    function automatic logic [31:0] br(int f3, int rs1, int rs2, int off);
        logic [12:0] o = 13'(off);
        return {o[12], o[10:5], 5'(rs2), 5'(rs1), 3'(f3), o[4:1], o[11], 7'h63};
    endfunction
    function automatic logic [31:0] jal(int rd, int off);
        logic [20:0] o = 21'(off);
        return {o[20], o[10:1], o[11], o[19:12], 5'(rd), 7'h6F};
    endfunction
    function automatic logic [31:0] jalr(int rd, int rs1, int imm); return enc_i(imm, rs1, 0, rd, 7'h67); endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Hold reset while the program image is written, then release on a falling edge.
    task automatic load_and_reset(input logic [31:0] p[$]);
        enable = 1'b0;
        rst    = 1'b0;
        for (int i = 0; i < 2048; i++) dut.m.bank[i] = '0;
        for (int i = 1024; i < 1030; i++) dut.m.bank[i] = SENT;
        foreach (p[i]) dut.m.bank[i] = p[i];
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_halt(input string name, input logic [31:0] exp_pc);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (halted) break;
        end
        check({name, " halted"}, 32'(halted), 32'd1);
        check({name, " halt_pc"}, pc, exp_pc);
    endtask

    task automatic wait_state(input state_t s, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (dut.state == s) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic drain();
        while (sbq.size() > 0) begin
            sb_t e = sbq.pop_front();
            check(e.name, dut.m.bank[e.idx], e.val);
        end
    endtask

    initial begin
        logic [31:0] p[$];
        logic [31:0] pc_before;
        int          acc;
        bit          ok;

        vecs[0]  = '{"add",   addi(1, 0, 5),        addi(2, 0, 7),  opr(0, 0, 3, 1, 2),     32'd12};
        vecs[1]  = '{"sub",   addi(1, 0, -3),       addi(2, 0, 5),  opr(32, 0, 3, 1, 2),    32'hFFFF_FFF8};
        vecs[2]  = '{"sra",   addi(1, 0, -16),      addi(2, 0, 2),  opr(32, 5, 3, 1, 2),    32'hFFFF_FFFC};
        vecs[3]  = '{"srl",   addi(1, 0, -16),      addi(2, 0, 2),  opr(0, 5, 3, 1, 2),     32'h3FFF_FFFC};
        vecs[4]  = '{"sll35", addi(1, 0, 1),        addi(2, 0, 35), opr(0, 1, 3, 1, 2),     32'd8};
        vecs[5]  = '{"slt_t", addi(1, 0, -1),       addi(2, 0, 1),  opr(0, 2, 3, 1, 2),     32'd1};
        vecs[6]  = '{"slt_f", addi(1, 0, 1),        addi(2, 0, -1), opr(0, 2, 3, 1, 2),     32'd0};
        vecs[7]  = '{"xor",   addi(1, 0, 240),      addi(2, 0, 255), opr(0, 4, 3, 1, 2),    32'h0000_000F};
        vecs[8]  = '{"and",   addi(1, 0, 240),      addi(2, 0, 255), opr(0, 7, 3, 1, 2),    32'h0000_00F0};
        vecs[9]  = '{"or",    addi(1, 0, 240),      addi(2, 0, 15), opr(0, 6, 3, 1, 2),     32'h0000_00FF};
        vecs[10] = '{"slti",  addi(1, 0, -5),       addi(0, 0, 0),  enc_i(-4, 1, 2, 3, 7'h13), 32'd1};
        vecs[11] = '{"srai",  addi(1, 0, -2048),    addi(0, 0, 0),  enc_i(32'h404, 1, 5, 3, 7'h13), 32'hFFFF_FF80};
        vecs[12] = '{"xori",  addi(1, 0, 5),        addi(0, 0, 0),  enc_i(-1, 1, 4, 3, 7'h13), 32'hFFFF_FFFA};
        vecs[13] = '{"lui",   addi(0, 0, 0),        addi(0, 0, 0),  lui(3, 32'hABCDE),      32'hABCD_E000};
        vecs[14] = '{"auipc", addi(0, 0, 0),        addi(0, 0, 0),  auipc(3, 1),            32'h0000_100C};
        vecs[15] = '{"wrap",  lui(1, 32'h80000),    addi(2, 0, -1), opr(0, 0, 3, 1, 2),     32'h7FFF_FFFF};

        // Reset state, then 100 idle cycles with enable low.
        p = {lui(31, 1), EBREAK};
        load_and_reset(p);
        #1;
        check("rst pc", pc, 32'h0);
        check("rst halted", 32'(halted), 32'd0);
        check("rst state", 32'(dut.state), 32'(IDLE));
        check("rst instr", dut.instr, 32'h0);
        acc = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (mon.read || mon.mem_wen) acc++;
        end
        check("idle accesses", 32'(acc), 32'd0);
        check("idle pc", pc, 32'h0);
        check("idle state", 32'(dut.state), 32'(IDLE));

        // Table: x1/x2 setup, op into x3, SW x3 to 4096, EBREAK at byte 20.
        for (int v = 0; v < 16; v++) begin
            p = {lui(31, 1), vecs[v].i0, vecs[v].i1, vecs[v].i2, sw(3, 31, 0), EBREAK};
            load_and_reset(p);
            sbq.push_back('{32'd1024, vecs[v].exp, vecs[v].name});
            enable = 1'b1;
            wait_halt(vecs[v].name, 32'd20);
            drain();
        end

        // Sum 1..10 with BNE, store at 4100.
        p = {lui(31, 1), addi(1, 0, 0), addi(2, 0, 1), addi(4, 0, 11),
             opr(0, 0, 1, 1, 2), addi(2, 2, 1), br(1, 2, 4, -8), sw(1, 31, 4), EBREAK};
        load_and_reset(p);
        sbq.push_back('{32'd1025, 32'd55, "sum"});
        enable = 1'b1;
        wait_halt("sum", 32'd32);
        drain();

        // Store/load round trip of 0xDEADBEEF.
        p = {lui(31, 1), lui(5, 32'hDEADC), addi(5, 5, -273), sw(5, 31, 8),
             lw(6, 31, 8), sw(6, 31, 12), EBREAK};
        load_and_reset(p);
        sbq.push_back('{32'd1026, 32'hDEAD_BEEF, "sw beef"});
        sbq.push_back('{32'd1027, 32'hDEAD_BEEF, "lw beef"});
        enable = 1'b1;
        wait_halt("beef", 32'd24);
        drain();

        // Branches, JAL link, JALR with odd target.
        p = {lui(31, 1), addi(1, 0, -1), addi(2, 0, 1), br(4, 1, 2, 8), EBREAK,
             br(5, 2, 1, 8), EBREAK, br(0, 1, 2, 8), jal(3, 12), EBREAK, EBREAK,
             addi(7, 0, 61), jalr(8, 7, 0), EBREAK, EBREAK, sw(3, 31, 16), sw(8, 31, 20), EBREAK};
        load_and_reset(p);
        sbq.push_back('{32'd1028, 32'd36, "jal link"});
        sbq.push_back('{32'd1029, 32'd52, "jalr link"});
        enable = 1'b1;
        wait_halt("jump", 32'd68);
        drain();

        // Reset asserted during the MEM cycle of a store drops the write.
        p = {lui(31, 1), addi(1, 0, 5), addi(2, 0, 7), opr(0, 0, 3, 1, 2), sw(3, 31, 0), EBREAK};
        load_and_reset(p);
        enable = 1'b1;
        wait_state(MEM, ok);
        check("reach mem", 32'(ok), 32'd1);
        rst = 1'b0;
        #1;
        check("abort state", 32'(dut.state), 32'(IDLE));
        check("abort pc", pc, 32'h0);
        check("abort x3", dut.regs[3], 32'h0);
        repeat (3) @(negedge clk);
        check("abort word", dut.m.bank[1024], SENT);

        // Enable dropped in EXEC: instruction completes, core parks in IDLE, then resumes.
        load_and_reset(p);
        enable = 1'b1;
        wait_state(EXEC, ok);
        check("reach exec", 32'(ok), 32'd1);
        pc_before = pc;
        enable = 1'b0;
        wait_state(IDLE, ok);
        check("pause idle", 32'(ok), 32'd1);
        check("pause pc", pc, pc_before + 32'd4);
        repeat (10) @(negedge clk);
        check("pause hold", pc, pc_before + 32'd4);
        sbq.push_back('{32'd1024, 32'd12, "resume sum"});
        enable = 1'b1;
        wait_halt("resume", 32'd20);
        drain();

        // Write to x0 is ignored; illegal opcode halts with no further bus traffic.
        p = {lui(31, 1), addi(0, 0, 9), sw(0, 31, 0), 32'h0000_007F, EBREAK};
        load_and_reset(p);
        sbq.push_back('{32'd1024, 32'd0, "x0 store"});
        enable = 1'b1;
        wait_halt("illegal", 32'd12);
        acc = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (mon.read || mon.mem_wen) acc++;
        end
        check("halt accesses", 32'(acc), 32'd0);
        check("halt sticky", 32'(halted), 32'd1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
